ice_ram_arbiter: RTL

- Two-requester round-robin arbiter and sequencer in front of one single-port ice_ram instance (1-cycle registered read latency, write-first dout).
- Requester A is the weight/activation loader; requester B is the compute engine.
- Also performs a sequenced memory clear, one address per cycle, so the RAM's one-cycle bulk reset is never used.

---
 rtl/ice_ram_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ice_ram_arbiter.sv
// ice_ram_arbiter
//   Two-requester round-robin arbiter and sequencer in front of one
//   single-port ice_ram (1-cycle registered read, write-first dout).
//   Requester A is the weight/activation loader, requester B the compute
//   engine. Also runs a sequenced memory clear, one address per cycle, so
//   the RAM's one-cycle bulk reset is never used (ram_rst is tied low).
//
// Optional build macro:
//   CLEAR_ON_RESET_EN - reset lands in CLEAR, so a full sweep runs as soon
//                       as rst is released, with no clear_req needed.
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-low reset
//   a_req_* / b_req_*        request channels: valid/ready/we/addr/wdata
//   a_rsp_* / b_rsp_*        read responses: valid (1 cycle), rdata (held)
//   clear_req, clear_busy    start / in-progress of the clear sweep
//   ram_rst, ram_we, ram_addr, ram_din, ram_dout   RAM-side interface
module ice_ram_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  ram_rst,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {SERVE, CLEAR} state_t;

`ifdef CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = SERVE;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state, state_next;
  logic                    prefer_b;      // 1: B wins the next tie
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;        // last address presented to the RAM
  logic                    a_pend, b_pend;
  logic [DATA_WIDTH-1:0]   a_hold, b_hold;
  logic                    grant_a, grant_b;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_din    = '0;
    case (state)
      SERVE: begin
        // A clear request takes the cycle; pending requests wait.
        if (clear_req) begin
          state_next = CLEAR;
        end else if (a_req_valid && b_req_valid) begin
          grant_a = !prefer_b;
          grant_b = prefer_b;
        end else begin
          grant_a = a_req_valid;
          grant_b = b_req_valid;
        end
        if (grant_a) begin
          ram_we   = a_req_we;
          ram_addr = a_req_addr;
          ram_din  = a_req_wdata;
        end else if (grant_b) begin
          ram_we   = b_req_we;
          ram_addr = b_req_addr;
          ram_din  = b_req_wdata;
        end
      end
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        if (clr_cnt == LAST_ADDR) state_next = SERVE;
      end
      default: state_next = SERVE;
    endcase
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign clear_busy  = (state == CLEAR);
  assign ram_rst     = 1'b0;
  assign a_rsp_valid = a_pend;
  assign b_rsp_valid = b_pend;

  // The RAM's registered dout is live in the response cycle; afterwards the
  // captured copy keeps rdata stable until the next response.
  assign a_rsp_rdata = a_pend ? ram_dout : a_hold;
  assign b_rsp_rdata = b_pend ? ram_dout : b_hold;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RESET_STATE;
      prefer_b <= 1'b0;
      clr_cnt  <= '0;
      addr_q   <= '0;
      a_pend   <= 1'b0;
      b_pend   <= 1'b0;
      a_hold   <= '0;
      b_hold   <= '0;
    end else begin
      state  <= state_next;
      addr_q <= ram_addr;
      if (grant_a || grant_b) prefer_b <= grant_a;
      a_pend <= grant_a && !a_req_we;
      b_pend <= grant_b && !b_req_we;
      if (a_pend) a_hold <= ram_dout;
      if (b_pend) b_hold <= ram_dout;
      // Wraps from LAST_ADDR back to 0 as the sweep ends.
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

endmodule
